// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main-memory responder and the data cache that
// talks to it. Both sides import this package so block geometry and latency
// defaults cannot drift apart.
package mem_resp_pkg;

  // Responder FSM encoding, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_BURST  = 2'd2,
    ST_COMMIT = 2'd3
  } mem_state_e;

  // Default geometry: words per cache block and access latency in cycles.
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_LATENCY     = 4;

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response bus between the data cache (master) and the main-memory
// responder (slave).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_ready depends only on responder state, never on
// req_valid. Responses carry no ready: every resp_valid beat and every
// wr_done pulse is presented for exactly one cycle and must be sunk.
interface mem_resp_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WORD_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [WORD_W-1:0] resp_word;
  logic              resp_last;
  logic              wr_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_word, resp_last, wr_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_word, resp_last, wr_done
  );
endinterface

// File: rtl/main_memory_responder_mem_array.sv
// Single-port synchronous RAM: one write or one read per cycle, read data
// registered (available the cycle after the read edge). Storage has no reset.
module main_mem_array #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write has priority; a read captures the addressed word into rdata_q.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Backing-store responder for the data cache. A read returns the whole
// aligned block as BLOCK_WORDS single-word beats starting at offset 0; a
// write commits one word. Both start LATENCY cycles after acceptance.
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 10,
  parameter int    MEM_DEPTH   = 1024,
  parameter int    BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int    LATENCY     = DEF_LATENCY,
  parameter string INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       rstn,
  mem_resp_if.slave  bus,
  output mem_state_e dbg_state
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] LAT_PRE  = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BLOCK_WORDS - 1);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  lat_cnt_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Read pipeline: rd_idx_q is the next block offset to fetch (0 = no fetch
  // pending), rd_vld_q/rd_word_q describe the word the RAM returns this cycle.
  logic [OFF_W-1:0]  rd_idx_q;
  logic              rd_vld_q;
  logic [OFF_W-1:0]  rd_word_q;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [OFF_W-1:0]  resp_word_q;
  logic              resp_last_q;
  logic              wr_done_q;

  logic              accept;
  logic              wait_last;
  logic              issue_first;
  logic              rd_more;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] base_src;
  logic [OFF_W-1:0]  rd_off;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [OFF_W-1:0]  rd_idx_d;
  logic [OFF_W-1:0]  rd_word_d;

  // Fetch scheduling and RAM port steering. The RAM read for beat k happens
  // one edge before the beat is registered, so beat 0 is fetched at edge
  // LATENCY-1 (the acceptance edge itself when LATENCY is 1).
  always_comb begin
    accept    = (state_q == ST_IDLE) && bus.req_valid;
    wait_last = (state_q == ST_WAIT) && (lat_cnt_q == LAT_LAST);
    if (LATENCY == 1) begin
      issue_first = accept && !bus.req_write;
    end else begin
      issue_first = (state_q == ST_WAIT) && !wr_q && (lat_cnt_q == LAT_PRE);
    end
    rd_more  = (rd_idx_q != '0);
    ram_re   = issue_first || rd_more;
    ram_we   = wait_last && wr_q;
    base_src = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
    rd_off   = issue_first ? '0 : rd_idx_q;
    // Offset replaces the low bits of the block base: stays inside the block
    // and wraps modulo the memory depth with no carry out of ADDR_W.
    ram_addr = ram_we ? addr_q : {base_src[ADDR_W-1:OFF_W], rd_off};

    rd_word_d = rd_off;
    rd_idx_d  = '0;
    if (issue_first) begin
      rd_idx_d = OFF_W'(1);
    end else if (rd_more && (rd_idx_q != OFF_LAST)) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
  end

  main_mem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (MEM_DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  // Control FSM, request capture, read pipeline and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_word_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_word_q  <= '0;
      resp_last_q  <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            wr_q      <= bus.req_write;
            lat_cnt_q <= '0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_last) begin
            lat_cnt_q <= '0;
            wr_done_q <= wr_q;
            state_q   <= wr_q ? ST_COMMIT : ST_BURST;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        ST_BURST: begin
          if (resp_last_q) state_q <= ST_IDLE;
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      rd_idx_q     <= rd_idx_d;
      rd_vld_q     <= ram_re;
      rd_word_q    <= rd_word_d;
      resp_valid_q <= rd_vld_q;
      resp_last_q  <= rd_vld_q && (rd_word_q == OFF_LAST);
      if (rd_vld_q) begin
        resp_data_q <= ram_rdata;
        resp_word_q <= rd_word_q;
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_word  = resp_word_q;
  assign bus.resp_last  = resp_last_q;
  assign bus.wr_done    = wr_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed scenarios plus a
// randomized read/write mix against a word-array reference model.
module tb_main_memory_responder;
  import mem_resp_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int BW     = 4;
  localparam int LAT    = 4;
  localparam int OFF_W  = 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  mem_state_e dbg_state;

  mem_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORD_W(OFF_W)) bus ();

  main_memory_responder #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .MEM_DEPTH  (DEPTH),
    .BLOCK_WORDS(BW),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Reference model and scoreboard.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.req_addr  = ADDR_W'($urandom);
    bus.req_wdata = $urandom;
    bus.req_write = 1'($urandom_range(0, 1));
  endtask

  // Drops rstn mid-cycle and checks the asynchronous clear, then releases.
  task automatic reset_abort(input string tag);
    rstn = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, bus.resp_valid, 0);
    chk({tag, "_rst_data"},  bus.resp_data,  0);
    chk({tag, "_rst_word"},  bus.resp_word,  0);
    chk({tag, "_rst_last"},  bus.resp_last,  0);
    chk({tag, "_rst_ready"}, bus.req_ready,  1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_rst_wrdone"}, bus.wr_done, 0);
    end
    rstn = 1'b1;
    exp_q.delete();
  endtask

  // Block refill; abort_n > 0 pulls reset in the cycle after edge abort_n.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input string tag, input int abort_n);
    int base;
    base = int'(addr) - (int'(addr) % BW);
    @(negedge clk);
    chk({tag, "_ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.req_wdata = $urandom;
    @(posedge clk);
    for (int k = 0; k < BW; k++) exp_q.push_back(model_mem[(base + k) % DEPTH]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    scramble_inputs();
    chk({tag, "_busy"}, bus.req_ready, 0);
    for (int n = 1; n <= LAT + BW; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n >= LAT && n < LAT + BW) begin
        logic [DATA_W-1:0] e;
        chk({tag, "_valid"}, bus.resp_valid, 1);
        chk({tag, "_word"}, bus.resp_word, n - LAT);
        chk({tag, "_last"}, bus.resp_last, (n == LAT + BW - 1) ? 1 : 0);
        if (exp_q.size() == 0) chk({tag, "_beat_extra"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, bus.resp_data, e);
        end
      end else begin
        chk({tag, "_novalid"}, bus.resp_valid, 0);
      end
      chk({tag, "_ready"}, bus.req_ready, (n == LAT + BW) ? 1 : 0);
      chk({tag, "_nowrdone"}, bus.wr_done, 0);
      if (n == abort_n) begin
        reset_abort(tag);
        return;
      end
    end
  endtask

  // Write-through; abort_n > 0 pulls reset before the commit edge.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input string tag, input int abort_n);
    @(negedge clk);
    chk({tag, "_ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    scramble_inputs();
    for (int n = 1; n <= LAT + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == abort_n) begin
        reset_abort(tag);
        return;
      end
      if (n == LAT) model_mem[addr] = data;
      chk({tag, "_wrdone"}, bus.wr_done, (n == LAT) ? 1 : 0);
      chk({tag, "_novalid"}, bus.resp_valid, 0);
      chk({tag, "_ready"}, bus.req_ready, (n == LAT + 1) ? 1 : 0);
    end
  endtask

  // Read followed by write with req_valid held high across the read.
  task automatic b2b(input logic [ADDR_W-1:0] raddr, input logic [ADDR_W-1:0] waddr,
                     input logic [DATA_W-1:0] wdata);
    int base, acc2, total;
    base  = int'(raddr) - (int'(raddr) % BW);
    acc2  = LAT + BW + 1;
    total = acc2 + LAT + 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = raddr;
    @(posedge clk);
    for (int k = 0; k < BW; k++) exp_q.push_back(model_mem[(base + k) % DEPTH]);
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = waddr;
    bus.req_wdata = wdata;
    for (int n = 1; n <= total; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == acc2) begin
        bus.req_valid = 1'b0;
        scramble_inputs();
      end
      if (n >= LAT && n < LAT + BW) begin
        logic [DATA_W-1:0] e;
        chk("b2b_valid", bus.resp_valid, 1);
        chk("b2b_word", bus.resp_word, n - LAT);
        if (exp_q.size() == 0) chk("b2b_beat_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("b2b_data", bus.resp_data, e);
        end
      end else begin
        chk("b2b_novalid", bus.resp_valid, 0);
      end
      if (n == acc2 + LAT) model_mem[waddr] = wdata;
      chk("b2b_ready", bus.req_ready, (n == LAT + BW || n == total) ? 1 : 0);
      chk("b2b_wrdone", bus.wr_done, (n == acc2 + LAT) ? 1 : 0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_valid", bus.resp_valid, 0);
    chk("reset_data", bus.resp_data, 0);
    chk("reset_word", bus.resp_word, 0);
    chk("reset_last", bus.resp_last, 0);
    chk("reset_wrdone", bus.wr_done, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    rstn = 1'b1;

    // Refill of a preloaded block from a mid-block address.
    for (int k = 0; k < 4; k++) do_write(ADDR_W'(8 + k), 32'hA0A0_0000 + k, "pre8", 0);
    do_read(10'h00A, "refill", 0);

    // Write-through then read returns the written word.
    do_write(10'h004, 32'h1111_0004, "pre4", 0);
    do_write(10'h006, 32'h1111_0006, "pre4", 0);
    do_write(10'h007, 32'h1111_0007, "pre4", 0);
    do_write(10'h005, 32'hDEAD_BEEF, "wt", 0);
    do_read(10'h004, "wt_rd", 0);

    // Block at the top of memory; word 0 holds a distinct value.
    do_write(10'h000, 32'h0BAD_0000, "prewrap", 0);
    for (int k = 0; k < 4; k++) do_write(ADDR_W'(12'h3FC + k), 32'hC0DE_03FC + k, "prewrap", 0);
    do_read(10'h3FF, "wrap", 0);

    // Reset during beat 1, then a normal request.
    do_read(10'h008, "rstburst", LAT + 1);
    do_read(10'h00A, "after_rst", 0);

    // Write aborted before commit leaves the old value.
    for (int k = 0; k < 4; k++) do_write(ADDR_W'(16 + k), 32'h5555_0010 + k, "pre10", 0);
    do_write(10'h010, 32'h1234_5678, "wabort", 2);
    do_read(10'h010, "wabort_rd", 0);

    // Back-to-back with req_valid held.
    b2b(10'h008, 10'h009, 32'hFACE_0009);
    do_read(10'h009, "b2b_rd", 0);

    // Randomized mix in a preloaded window.
    for (int a = 'h100; a < 'h140; a++) do_write(ADDR_W'(a), $urandom, "rnd_pre", 0);
    for (int i = 0; i < 30; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = ADDR_W'($urandom_range('h100, 'h13F));
      if ($urandom_range(0, 1) == 1) do_write(ra, $urandom, "rnd_wr", 0);
      else do_read(ra, "rnd_rd", 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
